operand_fetch: RTL

Operand-fetch and writeback stage that sits directly upstream of `alu`. Holds the SIZE x WORDSIZE register bank, accepts one instruction per cycle (rs1, rs2, rd, op) and presents registered `a_out`/`b_out`/`op_out` to the ALU. It then writes the ALU's combinational `result` back into `rd`. Back-to-back dependencies are resolved by forwarding, so there are no bubbles.

---
 rtl/alu_pkg.sv | 13 +
 rtl/reg_bank.sv | 46 ++++
 rtl/operand_fetch.sv | 106 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the operand-fetch stage and the ALU it feeds:
// opcode encodings and default datapath geometry.
package alu_pkg;

    localparam logic [4:0] OP_GET_A = 5'b00000;
    localparam logic [4:0] OP_GET_B = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;

    localparam int DEF_WORDSIZE = 64;
    localparam int DEF_SIZE     = 32;

endpackage

// File: rtl/reg_bank.sv
// SIZE x WORDSIZE register bank: two combinational read ports, a writeback
// port and a load port (writeback wins on the same address), async clear.
module reg_bank
    import alu_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int SIZE     = DEF_SIZE,
    parameter int ADDRW    = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRW-1:0]    rd_addr1,
    input  logic [ADDRW-1:0]    rd_addr2,
    output logic [WORDSIZE-1:0] rd_data1,
    output logic [WORDSIZE-1:0] rd_data2,
    input  logic                wb_en,
    input  logic [ADDRW-1:0]    wb_addr,
    input  logic [WORDSIZE-1:0] wb_data,
    input  logic                ld_en,
    input  logic [ADDRW-1:0]    ld_addr,
    input  logic [WORDSIZE-1:0] ld_data
);

    logic [WORDSIZE-1:0] regs [SIZE];

    assign rd_data1 = regs[rd_addr1];
    assign rd_data2 = regs[rd_addr2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                // A load colliding with a writeback to the same register is dropped.
                if (wb_en && wb_addr == ADDRW'(i)) begin
                    regs[i] <= wb_data;
                end else if (ld_en && ld_addr == ADDRW'(i)) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch / writeback stage feeding the ALU, with full forwarding.
// Optional: define OPERAND_FETCH_ZERO_REG_EN to hard-wire register 0 to zero.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int SIZE     = DEF_SIZE,
    parameter int ADDRW    = $clog2(SIZE)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDRW-1:0]    rs1,
    input  logic [ADDRW-1:0]    rs2,
    input  logic [ADDRW-1:0]    rd,
    input  logic [4:0]          op_in,
    input  logic                stall,
    input  logic                ld_en,
    input  logic [ADDRW-1:0]    ld_addr,
    input  logic [WORDSIZE-1:0] ld_data,
    output logic [WORDSIZE-1:0] a_out,
    output logic [WORDSIZE-1:0] b_out,
    output logic [4:0]          op_out,
    output logic                e_valid,
    input  logic [WORDSIZE-1:0] result_in
);

    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
    // in_ready is simply !stall, and in_valid may change freely while not ready.
    logic                accept;
    logic                wb_en;
    logic                wb_we;
    logic                ld_we;
    logic [ADDRW-1:0]    e_rd;
    logic [WORDSIZE-1:0] bank_rd1;
    logic [WORDSIZE-1:0] bank_rd2;
    logic [WORDSIZE-1:0] fwd1;
    logic [WORDSIZE-1:0] fwd2;

    assign in_ready = !stall;
    assign accept   = in_valid && !stall;
    assign wb_en    = e_valid && !stall;

`ifdef OPERAND_FETCH_ZERO_REG_EN
    assign wb_we = wb_en && (e_rd != '0);
    assign ld_we = ld_en && (ld_addr != '0);
`else
    assign wb_we = wb_en;
    assign ld_we = ld_en;
`endif

    reg_bank #(
        .WORDSIZE (WORDSIZE),
        .SIZE     (SIZE),
        .ADDRW    (ADDRW)
    ) u_reg_bank (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr1 (rs1),
        .rd_addr2 (rs2),
        .rd_data1 (bank_rd1),
        .rd_data2 (bank_rd2),
        .wb_en    (wb_we),
        .wb_addr  (e_rd),
        .wb_data  (result_in),
        .ld_en    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    // Pending writeback beats a same-edge load, which beats the stored value.
    function automatic logic [WORDSIZE-1:0] fwd_sel(
        input logic [ADDRW-1:0]    rs,
        input logic [WORDSIZE-1:0] bank_val
    );
`ifdef OPERAND_FETCH_ZERO_REG_EN
        if (rs == '0) return '0;
`endif
        if (wb_en && e_rd == rs) return result_in;
        if (ld_en && ld_addr == rs) return ld_data;
        return bank_val;
    endfunction

    assign fwd1 = fwd_sel(rs1, bank_rd1);
    assign fwd2 = fwd_sel(rs2, bank_rd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
            op_out  <= '0;
            e_rd    <= '0;
        end else if (!stall) begin
            e_valid <= accept;
            if (accept) begin
                a_out  <= fwd1;
                b_out  <= fwd2;
                op_out <= op_in;
                e_rd   <= rd;
            end
        end
    end

endmodule
